lab3_mem_cache_mem_arbiter: RTL and testbench

- Sits between the p_num_banks blocking cache banks and the single test memory port.
- Merges each bank's cache2mem request stream (refills and evictions) onto one memory request stream using round-robin arbitration.
- Drives the memory request through a one-entry output buffer.
- Steers each memory response back to the issuing bank by a bank-id tag carried in the opaque field.

---
 rtl/lab3_mem_cache_mem_arbiter_pkg.sv | 42 ++++
 rtl/lab3_mem_cache_mem_arbiter_if.sv | 30 +++
 rtl/lab3_mem_rr_arb.sv | 42 ++++
 rtl/lab3_mem_cache_mem_arbiter.sv | 108 ++++++++++
 tb/tb_lab3_mem_cache_mem_arbiter.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lab3_mem_cache_mem_arbiter_pkg.sv
// Shared constants and message types for the cache-bank to memory arbiter.
package lab3_mem_cache_mem_arbiter_pkg;

   localparam int OPQ_W   = 8;
   localparam int TAG_LSB = 0;   // bank-id tag lives in the low bits of opaque
   localparam int LEGAL_BANKS [3] = '{1, 2, 4};

   typedef enum logic [2:0] {
      MEM_READ  = 3'd0,
      MEM_WRITE = 3'd1,
      MEM_INIT  = 3'd2
   } mem_type_e;

   typedef struct packed {
      mem_type_e          type_;
      logic [OPQ_W-1:0]   opaque;
      logic [31:0]        addr;
      logic [3:0]         len;
      logic [127:0]       data;
   } mem_req_16B_t;

   typedef struct packed {
      mem_type_e          type_;
      logic [OPQ_W-1:0]   opaque;
      logic [1:0]         test;
      logic [3:0]         len;
      logic [127:0]       data;
   } mem_resp_16B_t;

   // Width of a bank-id tag; never narrower than one bit.
   function automatic int bank_bits(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic bit legal_num_banks(input int n);
      bit ok;
      ok = 1'b0;
      foreach (LEGAL_BANKS[k]) if (LEGAL_BANKS[k] == n) ok = 1'b1;
      return ok;
   endfunction

endpackage

// File: rtl/lab3_mem_cache_mem_arbiter_if.sv
// Bank-side and memory-side val/rdy streams of the arbiter.
interface lab3_mem_cache_mem_arbiter_if #(parameter int p_num_banks = 4);
   import lab3_mem_cache_mem_arbiter_pkg::*;

   mem_req_16B_t  [p_num_banks-1:0] bankreq_msg;
   logic          [p_num_banks-1:0] bankreq_val;
   logic          [p_num_banks-1:0] bankreq_rdy;
   mem_resp_16B_t [p_num_banks-1:0] bankresp_msg;
   logic          [p_num_banks-1:0] bankresp_val;
   logic          [p_num_banks-1:0] bankresp_rdy;
   mem_req_16B_t                    memreq_msg;
   logic                            memreq_val;
   logic                            memreq_rdy;
   mem_resp_16B_t                   memresp_msg;
   logic                            memresp_val;
   logic                            memresp_rdy;

   // Arbiter side
   modport slave (
      input  bankreq_msg, bankreq_val, bankresp_rdy, memreq_rdy, memresp_msg, memresp_val,
      output bankreq_rdy, bankresp_msg, bankresp_val, memreq_msg, memreq_val, memresp_rdy
   );

   // Banks plus memory, seen from outside the arbiter
   modport master (
      output bankreq_msg, bankreq_val, bankresp_rdy, memreq_rdy, memresp_msg, memresp_val,
      input  bankreq_rdy, bankresp_msg, bankresp_val, memreq_msg, memreq_val, memresp_rdy
   );

endinterface

// File: rtl/lab3_mem_rr_arb.sv
// Round-robin arbiter: one-hot grant scanning from an internal priority
// pointer; the pointer moves past the winner only when a grant is issued.
module lab3_mem_rr_arb
   import lab3_mem_cache_mem_arbiter_pkg::*;
#(
   parameter int p_num      = 4,
   parameter int p_ptr_bits = bank_bits(p_num)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [p_num-1:0] req,
   input  logic             en,
   output logic [p_num-1:0] grant
);

   logic [p_ptr_bits-1:0] ptr_q, ptr_d;

   // Scan requesters starting at the pointer; first hit wins
   always_comb begin
      int   idx;
      logic found;
      idx   = 0;
      found = 1'b0;
      grant = '0;
      ptr_d = ptr_q;
      for (int k = 0; k < p_num; k++) begin
         idx = (int'(ptr_q) + k) % p_num;
         if (en && !found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
            ptr_d      = p_ptr_bits'((idx + 1) % p_num);
         end
      end
   end

   // Priority pointer register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end

endmodule

// File: rtl/lab3_mem_cache_mem_arbiter.sv
// Merges per-bank refill/evict requests onto one memory port through a
// one-entry buffer, tagging opaque with the bank id, and steers responses
// back by that tag while restoring each bank's original opaque.
module lab3_mem_cache_mem_arbiter
   import lab3_mem_cache_mem_arbiter_pkg::*;
#(
   parameter int p_num_banks = 4,
   parameter int p_bank_bits = bank_bits(p_num_banks)
) (
   input  logic                          clk,
   input  logic                          reset,
   lab3_mem_cache_mem_arbiter_if.slave   bus
);

   logic                              buf_val_q, buf_val_d;
   mem_req_16B_t                      buf_msg_q, buf_msg_d;
   logic [p_num_banks-1:0]            outstanding_q, outstanding_d;
   logic [p_num_banks-1:0][OPQ_W-1:0] saved_opaque_q, saved_opaque_d;

   logic [p_num_banks-1:0]            eligible, grant, resp_hit;
   logic                              can_accept, resp_rdy, resp_fire;
   logic [p_bank_bits-1:0]            resp_tag;
   mem_req_16B_t                      gnt_msg;
   mem_resp_16B_t [p_num_banks-1:0]   resp_lane;

   // Buffer accepts when empty or when its current entry leaves this cycle
   assign can_accept = !buf_val_q || bus.memreq_rdy;
   assign eligible   = bus.bankreq_val & ~outstanding_q;

   lab3_mem_rr_arb #(.p_num(p_num_banks)) u_arb (
      .clk   (clk),
      .reset (reset),
      .req   (eligible),
      .en    (can_accept),
      .grant (grant)
   );

   assign bus.bankreq_rdy = grant;
   assign bus.memreq_val  = buf_val_q;
   assign bus.memreq_msg  = buf_msg_q;

   assign resp_tag = bus.memresp_msg.opaque[TAG_LSB +: p_bank_bits];

   for (genvar i = 0; i < p_num_banks; i++) begin : g_lane
      assign resp_hit[i]         = (resp_tag == p_bank_bits'(i));
      assign bus.bankresp_val[i] = bus.memresp_val && resp_hit[i];
   end

   assign resp_rdy         = |(bus.bankresp_rdy & resp_hit);
   assign resp_fire        = bus.memresp_val && resp_rdy;
   assign bus.memresp_rdy  = resp_rdy;
   assign bus.bankresp_msg = resp_lane;

   // Every lane sees the memory response with its own saved opaque restored
   always_comb begin
      for (int i = 0; i < p_num_banks; i++) begin
         resp_lane[i]        = bus.memresp_msg;
         resp_lane[i].opaque = saved_opaque_q[i];
      end
   end

   // Select the granted bank's request and replace opaque with its bank id
   always_comb begin
      gnt_msg = '0;
      for (int i = 0; i < p_num_banks; i++) begin
         if (grant[i]) begin
            gnt_msg        = bus.bankreq_msg[i];
            gnt_msg.opaque = OPQ_W'(i);
         end
      end
   end

   // Next state: buffer drain/load, per-bank in-flight tracking
   always_comb begin
      buf_val_d      = buf_val_q;
      buf_msg_d      = buf_msg_q;
      outstanding_d  = outstanding_q;
      saved_opaque_d = saved_opaque_q;
      if (buf_val_q && bus.memreq_rdy) buf_val_d = 1'b0;
      if (|grant) begin
         buf_val_d = 1'b1;
         buf_msg_d = gnt_msg;
      end
      for (int i = 0; i < p_num_banks; i++) begin
         if (resp_fire && resp_hit[i]) outstanding_d[i] = 1'b0;
         if (grant[i]) begin
            outstanding_d[i]  = 1'b1;
            saved_opaque_d[i] = bus.bankreq_msg[i].opaque;
         end
      end
   end

   // State registers; reset drops any buffered or in-flight transaction
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         buf_val_q      <= 1'b0;
         buf_msg_q      <= '0;
         outstanding_q  <= '0;
         saved_opaque_q <= '0;
      end else begin
         buf_val_q      <= buf_val_d;
         buf_msg_q      <= buf_msg_d;
         outstanding_q  <= outstanding_d;
         saved_opaque_q <= saved_opaque_d;
      end
   end

endmodule

// File: tb/tb_lab3_mem_cache_mem_arbiter.sv
// Directed bench for the cache-bank to memory arbiter (4 banks).
module tb_lab3_mem_cache_mem_arbiter;
   import lab3_mem_cache_mem_arbiter_pkg::*;

   localparam int NB = 4;

   logic clk = 1'b0;
   logic reset;
   int   nvec = 0;
   int   nerr = 0;
   logic [NB-1:0] mon_out;

   logic [3:0] exp_gnt [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
   logic [7:0] exp_tag [6] = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h00};

   lab3_mem_cache_mem_arbiter_if #(.p_num_banks(NB)) bus ();

   lab3_mem_cache_mem_arbiter #(.p_num_banks(NB)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic mem_req_16B_t mk_req(input logic [7:0] opq, input logic [31:0] addr);
      mem_req_16B_t r;
      r        = '0;
      r.type_  = MEM_READ;
      r.opaque = opq;
      r.addr   = addr;
      return r;
   endfunction

   function automatic mem_resp_16B_t mk_resp(input logic [7:0] opq, input logic [127:0] data);
      mem_resp_16B_t r;
      r        = '0;
      r.type_  = MEM_READ;
      r.opaque = opq;
      r.data   = data;
      return r;
   endfunction

   task automatic do_reset();
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   // Protocol guard: memory must never answer a bank with nothing in flight
   always @(negedge clk) begin
      #4;
      if (!reset) mon_out <= '0;
      else begin
         for (int i = 0; i < NB; i++) begin
            if (bus.memresp_val && bus.memresp_rdy && bus.bankresp_val[i]) begin
               assert (mon_out[i] === 1'b1) else begin
                  nerr++;
                  $error("FAIL resp_to_idle_bank bank=%0d outstanding=0 required=1", i);
               end
               mon_out[i] <= 1'b0;
            end
            if (bus.bankreq_val[i] && bus.bankreq_rdy[i]) mon_out[i] <= 1'b1;
         end
      end
   end

   initial begin
      reset            = 1'b0;
      mon_out          = '0;
      bus.bankreq_msg  = '0;
      bus.bankreq_val  = 4'b1111;
      bus.bankresp_rdy = 4'b1111;
      bus.memreq_rdy   = 1'b0;
      bus.memresp_msg  = '0;
      bus.memresp_val  = 1'b0;

      // Reset state: empty buffer, pointer at bank 0, nothing outstanding
      #2;
      chk("rst_memreq_val", bus.memreq_val, 1'b0);
      chk("rst_bankresp_val", bus.bankresp_val, 4'b0000);
      chk("rst_first_grant", bus.bankreq_rdy, 4'b0001);
      bus.bankreq_val = 4'b0000;
      @(negedge clk);
      reset = 1'b1;

      // Single bank 0 read: tag replaces opaque, response restores it
      bus.bankreq_msg[0] = mk_req(8'h5A, 32'h0000_1000);
      bus.bankreq_val    = 4'b0001;
      bus.memreq_rdy     = 1'b1;
      #1 chk("t1_grant", bus.bankreq_rdy, 4'b0001);
      @(negedge clk);
      bus.bankreq_val = 4'b0000;
      #1;
      chk("t1_memreq_val", bus.memreq_val, 1'b1);
      chk("t1_memreq_opq", bus.memreq_msg.opaque, 8'h00);
      chk("t1_memreq_addr", bus.memreq_msg.addr, 32'h0000_1000);
      @(negedge clk);
      bus.memresp_msg = mk_resp(8'h00, 128'hDEAD_BEEF);
      bus.memresp_val = 1'b1;
      #1;
      chk("t1_memreq_drained", bus.memreq_val, 1'b0);
      chk("t1_resp_val", bus.bankresp_val, 4'b0001);
      chk("t1_resp_opq", bus.bankresp_msg[0].opaque, 8'h5A);
      chk("t1_resp_data", bus.bankresp_msg[0].data, 128'hDEAD_BEEF);
      chk("t1_memresp_rdy", bus.memresp_rdy, 1'b1);
      @(negedge clk);
      bus.memresp_val = 1'b0;
      bus.bankreq_val = 4'b0001;
      #1 chk("t1_regrant", bus.bankreq_rdy, 4'b0001);
      bus.bankreq_val = 4'b0000;
      do_reset();

      // All banks valid, memory always ready, responses 2 cycles after issue
      for (int i = 0; i < NB; i++) bus.bankreq_msg[i] = mk_req(8'(8'h10 + i), 32'(32'h100 * i));
      bus.bankreq_val = 4'b1111;
      bus.memreq_rdy  = 1'b1;
      for (int c = 0; c < 6; c++) begin
         bus.memresp_val = (c == 3) || (c == 4);
         bus.memresp_msg = mk_resp(8'(c - 3), 128'h0);
         #1;
         chk($sformatf("t2_grant_c%0d", c), bus.bankreq_rdy, exp_gnt[c]);
         if (c > 0) chk($sformatf("t2_memreq_tag_c%0d", c), bus.memreq_msg.opaque, exp_tag[c]);
         if (c == 3) chk("t2_resp0_opq", bus.bankresp_msg[0].opaque, 8'h10);
         if (c == 4) chk("t2_resp1_opq", bus.bankresp_msg[1].opaque, 8'h11);
         @(negedge clk);
      end
      bus.bankreq_val = 4'b0000;
      bus.memresp_val = 1'b0;
      do_reset();

      // Memory stalled: bank 1 request held, bank 2 waits for pipelined replace
      bus.bankreq_msg[1] = mk_req(8'h31, 32'h0000_0040);
      bus.bankreq_msg[2] = mk_req(8'h32, 32'h0000_0080);
      bus.bankreq_msg[3] = mk_req(8'h33, 32'h0000_00C0);
      bus.bankreq_val    = 4'b0110;
      bus.memreq_rdy     = 1'b0;
      #1 chk("t3_grant_b1", bus.bankreq_rdy, 4'b0010);
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         #1;
         chk($sformatf("t3_hold_val_%0d", k), bus.memreq_val, 1'b1);
         chk($sformatf("t3_hold_addr_%0d", k), bus.memreq_msg.addr, 32'h0000_0040);
         chk($sformatf("t3_hold_opq_%0d", k), bus.memreq_msg.opaque, 8'h01);
         chk($sformatf("t3_no_grant_%0d", k), bus.bankreq_rdy, 4'b0000);
         @(negedge clk);
      end
      bus.memreq_rdy = 1'b1;
      #1;
      chk("t3_replace_val", bus.memreq_val, 1'b1);
      chk("t3_replace_grant", bus.bankreq_rdy, 4'b0100);
      @(negedge clk);
      bus.bankreq_val = 4'b1000;
      #1;
      chk("t3_b2_val", bus.memreq_val, 1'b1);
      chk("t3_b2_opq", bus.memreq_msg.opaque, 8'h02);
      chk("t3_b2_addr", bus.memreq_msg.addr, 32'h0000_0080);
      chk("t3_b3_grant", bus.bankreq_rdy, 4'b1000);
      @(negedge clk);
      bus.bankreq_val = 4'b0000;
      #1 chk("t3_b3_opq", bus.memreq_msg.opaque, 8'h03);
      @(negedge clk);

      // Out-of-order responses: bank 3 stalled by its own rdy, then bank 1
      bus.bankresp_rdy = 4'b0111;
      bus.memresp_msg  = mk_resp(8'h03, 128'h3333);
      bus.memresp_val  = 1'b1;
      #1 chk("t4_memreq_idle", bus.memreq_val, 1'b0);
      for (int k = 0; k < 2; k++) begin
         if (k > 0) #1;
         chk($sformatf("t4_stall_rdy_%0d", k), bus.memresp_rdy, 1'b0);
         chk($sformatf("t4_stall_val_%0d", k), bus.bankresp_val, 4'b1000);
         @(negedge clk);
      end
      bus.bankresp_rdy = 4'b1111;
      #1;
      chk("t4_b3_rdy", bus.memresp_rdy, 1'b1);
      chk("t4_b3_opq", bus.bankresp_msg[3].opaque, 8'h33);
      chk("t4_b3_data", bus.bankresp_msg[3].data, 128'h3333);
      @(negedge clk);
      bus.memresp_msg = mk_resp(8'h01, 128'h1111);
      #1;
      chk("t4_b1_val", bus.bankresp_val, 4'b0010);
      chk("t4_b1_opq", bus.bankresp_msg[1].opaque, 8'h31);
      chk("t4_b1_rdy", bus.memresp_rdy, 1'b1);
      @(negedge clk);

      // Response to bank 2 and grant to bank 0 in the same cycle
      bus.bankreq_msg[0] = mk_req(8'h20, 32'h0000_0200);
      bus.bankreq_val    = 4'b0101;
      bus.memresp_msg    = mk_resp(8'h02, 128'h2222);
      #1;
      chk("t5_grant_b0", bus.bankreq_rdy, 4'b0001);
      chk("t5_resp_val", bus.bankresp_val, 4'b0100);
      chk("t5_resp_opq", bus.bankresp_msg[2].opaque, 8'h32);
      @(negedge clk);
      bus.memresp_val = 1'b0;
      bus.bankreq_val = 4'b0100;
      #1;
      chk("t5_regrant_b2", bus.bankreq_rdy, 4'b0100);
      chk("t5_memreq_b0", bus.memreq_msg.opaque, 8'h00);
      @(negedge clk);
      bus.bankreq_val = 4'b0010;
      #1;
      chk("t5_grant_b1", bus.bankreq_rdy, 4'b0010);
      chk("t5_memreq_b2", bus.memreq_msg.opaque, 8'h02);
      @(negedge clk);

      // Async reset with a full buffer and banks 0, 1, 2 outstanding
      bus.bankreq_val = 4'b0000;
      bus.memreq_rdy  = 1'b0;
      #1;
      chk("t6_full_val", bus.memreq_val, 1'b1);
      chk("t6_full_opq", bus.memreq_msg.opaque, 8'h01);
      reset = 1'b0;
      #1 chk("t6_async_clear", bus.memreq_val, 1'b0);
      @(negedge clk);
      reset           = 1'b1;
      bus.bankreq_val = 4'b1111;
      #1 chk("t6_first_grant", bus.bankreq_rdy, 4'b0001);
      @(negedge clk);
      bus.bankreq_val = 4'b0000;
      #1;
      chk("t6_memreq_val", bus.memreq_val, 1'b1);
      chk("t6_memreq_opq", bus.memreq_msg.opaque, 8'h00);
      chk("t6_memreq_addr", bus.memreq_msg.addr, 32'h0000_0200);
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
